// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: word storage with byte-enable writes,
// programmable wait states, ready handshakes and a sticky out-of-range flag.
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic        data_read_enable,
    input  logic        data_write_enable,
    input  logic [3:0]  data_write_byte_enable,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_read_rdy,
    output logic        data_write_rdy,
    output logic        access_error
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [31:2]        addr_r;
    logic [3:0]         be_r;
    logic [31:0]        wdata_r;
    logic               rd_r;
    logic               wr_r;

    logic [31:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0]  idx_s;
    logic               in_range_s;
    logic               unused_s;

    // Merge write lanes into the stored word under the byte enables.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Word index and range check of the latched address; byte offset bits are ignored.
    always_comb begin
        idx_s      = addr_r[ADDR_W+1:2];
        in_range_s = (addr_r[31:ADDR_W+2] == '0);
    end

    assign unused_s = ^data_address[1:0];

    // Handshake FSM, request latching and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            cnt_r          <= 4'd0;
            addr_r         <= 30'd0;
            be_r           <= 4'd0;
            wdata_r        <= 32'd0;
            rd_r           <= 1'b0;
            wr_r           <= 1'b0;
            data_read_data <= 32'd0;
            data_read_rdy  <= 1'b0;
            data_write_rdy <= 1'b0;
            access_error   <= 1'b0;
        end else begin
            data_read_rdy  <= 1'b0;
            data_write_rdy <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (data_read_enable || data_write_enable) begin
                        addr_r  <= data_address[31:2];
                        be_r    <= data_write_byte_enable;
                        wdata_r <= data_write_data;
                        rd_r    <= data_read_enable;
                        wr_r    <= data_write_enable;
                        cnt_r   <= 4'(WAIT_STATES);
                        state_r <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                    end
                    cnt_r <= cnt_r - 4'd1;
                end
                RESP: begin
                    // Read sees the pre-write word when both ops were requested together.
                    if (rd_r) begin
                        data_read_data <= in_range_s ? mem_r[idx_s] : 32'd0;
                    end
                    if (!in_range_s) begin
                        access_error <= 1'b1;
                    end
                    data_read_rdy  <= rd_r;
                    data_write_rdy <= wr_r;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Storage has no reset so it can map onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (state_r == RESP && wr_r && in_range_s) begin
            mem_r[idx_s] <= byte_merge(mem_r[idx_s], wdata_r, be_r);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states) driven by directed
// and random accesses, checked against a simple word-array model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic [3:0]  be    [2];
    logic [1:0]  re, we, rrdy, wrdy, aerr;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem_m   [2][16];
    bit          aerr_m  [2];
    logic [31:0] rdata_m [2];
    int          ws      [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .data_address(addr[0]), .data_read_enable(re[0]), .data_write_enable(we[0]),
        .data_write_byte_enable(be[0]), .data_write_data(wd[0]),
        .data_read_data(rdata[0]), .data_read_rdy(rrdy[0]), .data_write_rdy(wrdy[0]),
        .access_error(aerr[0])
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .data_address(addr[1]), .data_read_enable(re[1]), .data_write_enable(we[1]),
        .data_write_byte_enable(be[1]), .data_write_data(wd[1]),
        .data_read_data(rdata[1]), .data_read_rdy(rrdy[1]), .data_write_rdy(wrdy[1]),
        .access_error(aerr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d; enables dropped as soon as rdy is seen.
    task automatic do_op(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] data);
        int          n;
        bit          got;
        bit          inr;
        logic [31:0] old_word;
        inr      = (a < 32'h0000_1000);
        old_word = inr ? mem_m[d][a[5:2]] : 32'h0;
        @(negedge clk);
        addr[d] = a; be[d] = b; wd[d] = data; re[d] = r; we[d] = w;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = rrdy[d] | wrdy[d];
        end
        re[d] = 1'b0;
        we[d] = 1'b0;
        check($sformatf("latency_d%0d", d), n, ws[d] + 2);
        check("read_rdy", {31'd0, rrdy[d]}, {31'd0, r});
        check("write_rdy", {31'd0, wrdy[d]}, {31'd0, w});
        if (r) rdata_m[d] = old_word;
        check($sformatf("read_data_d%0d_a%h", d, a), rdata[d], rdata_m[d]);
        if (w && inr) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mem_m[d][a[5:2]][8*i +: 8] = data[8*i +: 8];
        end
        if (!inr) aerr_m[d] = 1'b1;
        check("access_error", {31'd0, aerr[d]}, {31'd0, aerr_m[d]});
        @(posedge clk); #1;
        check("rdy_pulse_width", {30'd0, rrdy[d], wrdy[d]}, 32'd0);
    endtask

    initial begin
        int n;
        bit got;
        ws[0] = 0;
        ws[1] = 3;
        rst = 1'b0;
        re = 2'b00; we = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 32'd0; wd[d] = 32'd0; be[d] = 4'd0;
            aerr_m[d] = 1'b0; rdata_m[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_rdata", rdata[d], 32'd0);
            check("reset_rdys", {30'd0, rrdy[d], wrdy[d]}, 32'd0);
            check("reset_aerr", {31'd0, aerr[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Fill the 16 words used by the model on both instances.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                do_op(d, 1'b0, 1'b1, 32'(i * 4), 4'b1111, $urandom);

        // Zero wait states: full write then read back.
        do_op(0, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
        do_op(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        check("deadbeef_literal", rdata[0], 32'hDEAD_BEEF);

        // Byte merge.
        do_op(0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h1122_3344);
        do_op(0, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        do_op(0, 1'b1, 1'b0, 32'h20, 4'b0000, 32'h0);
        check("byte_merge_literal", rdata[0], 32'h11BB_33DD);
        do_op(0, 1'b0, 1'b1, 32'h24, 4'b0000, 32'hFFFF_FFFF);
        do_op(0, 1'b1, 1'b0, 32'h27, 4'b0000, 32'h0);

        // Simultaneous read and write.
        do_op(0, 1'b0, 1'b1, 32'h30, 4'b1111, 32'h5);
        do_op(0, 1'b1, 1'b1, 32'h30, 4'b1111, 32'h9);
        check("rw_old_literal", rdata[0], 32'h5);
        do_op(0, 1'b1, 1'b0, 32'h30, 4'b0000, 32'h0);
        check("rw_new_literal", rdata[0], 32'h9);

        // Out of range accesses.
        do_op(0, 1'b1, 1'b0, 32'h1000, 4'b0000, 32'h0);
        check("oor_read_literal", rdata[0], 32'h0);
        do_op(0, 1'b0, 1'b1, 32'h1004, 4'b1111, 32'hCAFE_F00D);
        do_op(0, 1'b1, 1'b0, 32'h4, 4'b0000, 32'h0);
        check("oor_aerr_sticky", {31'd0, aerr[0]}, 32'd1);

        // Three wait states, then enables held through the response.
        do_op(1, 1'b1, 1'b0, 32'h8, 4'b0000, 32'h0);
        @(negedge clk);
        addr[1] = 32'h20; re[1] = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++; got = rrdy[1];
        end
        check("held_first_latency", n, 32'd5);
        rdata_m[1] = mem_m[1][8];
        check("held_first_data", rdata[1], rdata_m[1]);
        got = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++; got = rrdy[1];
        end
        re[1] = 1'b0;
        check("held_reaccept_gap", n, 32'd5);
        check("held_second_data", rdata[1], rdata_m[1]);
        @(posedge clk); #1;
        check("held_pulse_width", {31'd0, rrdy[1]}, 32'd0);

        // Random traffic on both instances.
        for (int k = 0; k < 120; k++) begin
            int d, op;
            logic [31:0] a;
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
            else                          a = 32'h1000 + 32'($urandom_range(0, 65535));
            do_op(d, op != 1, op != 0, a, 4'($urandom), $urandom);
        end

        // Reset during the wait phase of instance 1.
        @(negedge clk);
        addr[1] = 32'h10; re[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        re[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("midreset_rdata", rdata[d], 32'd0);
            check("midreset_rdys", {30'd0, rrdy[d], wrdy[d]}, 32'd0);
            check("midreset_aerr", {31'd0, aerr[d]}, 32'd0);
            aerr_m[d] = 1'b0; rdata_m[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("midreset_no_rdy", {30'd0, rrdy[1], wrdy[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Storage survives reset.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                do_op(d, 1'b1, 1'b0, 32'(i * 4), 4'b0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
